decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 168 ++++++++++++++++
 tb/tb_decode.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// RV32I decode stage: registered ALU/regfile fields behind a valid/ready handshake.
// Define DECODE_SKID_EN for a two-entry skid buffer with registered in_ready.
package decode_pkg;

    typedef enum logic [3:0] {
        i_ADD, i_SUB, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_SRA, i_OR, i_AND
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic        is_imm;
        logic [31:0] imm_i;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic        illegal;
    } dec_t;

endpackage

module decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output alu_op_t     alu_op,
    output logic        is_imm,
    output logic [31:0] imm_i,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        illegal
);

    dec_t dec_d;
    dec_t out_q;
    logic out_valid_q;
    logic legal;

    always_comb begin
        dec_d          = '0;
        legal          = 1'b0;
        dec_d.alu_op   = i_ADD;
        dec_d.imm_i    = {{20{instr[31]}}, instr[31:20]};
        dec_d.rs1_addr = instr[19:15];
        dec_d.rs2_addr = instr[24:20];
        dec_d.rd_addr  = instr[11:7];
        if (instr[6:0] == 7'b0110011) begin
            if (instr[31:25] == 7'b0000000) begin
                legal = 1'b1;
                case (instr[14:12])
                    3'b000:  dec_d.alu_op = i_ADD;
                    3'b001:  dec_d.alu_op = i_SLL;
                    3'b010:  dec_d.alu_op = i_SLT;
                    3'b011:  dec_d.alu_op = i_SLTU;
                    3'b100:  dec_d.alu_op = i_XOR;
                    3'b101:  dec_d.alu_op = i_SRL;
                    3'b110:  dec_d.alu_op = i_OR;
                    default: dec_d.alu_op = i_AND;
                endcase
            end else if (instr[31:25] == 7'b0100000) begin
                if (instr[14:12] == 3'b000) begin
                    legal        = 1'b1;
                    dec_d.alu_op = i_SUB;
                end else if (instr[14:12] == 3'b101) begin
                    legal        = 1'b1;
                    dec_d.alu_op = i_SRA;
                end
            end
        end else if (instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000) begin
            legal        = 1'b1;
            dec_d.is_imm = 1'b1;
        end
        dec_d.illegal = !legal;
        dec_d.rd_we   = legal && (instr[11:7] != 5'd0);
    end

`ifdef DECODE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q;
    dec_t   skid_q;
    logic   in_ready_q;
    logic   in_fire;
    logic   out_fire;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;
    assign in_ready = in_ready_q;

    // out_q is always the oldest entry; skid_q only holds a second one in FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        out_q       <= dec_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_q <= dec_d;
                    end else if (in_fire) begin
                        skid_q     <= dec_d;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_q      <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_q       <= dec_d;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign alu_op    = out_q.alu_op;
    assign is_imm    = out_q.is_imm;
    assign imm_i     = out_q.imm_i;
    assign rs1_addr  = out_q.rs1_addr;
    assign rs2_addr  = out_q.rs2_addr;
    assign rd_addr   = out_q.rd_addr;
    assign rd_we     = out_q.rd_we;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Randomized self-checking bench for decode against a queue-based reference model.
module tb_decode;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    alu_op_t     alu_op;
    logic        is_imm;
    logic [31:0] imm_i;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, illegal;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    dec_t        model_q[$];
    logic        post_rst = 1'b0;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .is_imm(is_imm), .imm_i(imm_i),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rd_we(rd_we), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic dec_t observed();
        dec_t d;
        d.alu_op = alu_op; d.is_imm = is_imm; d.imm_i = imm_i;
        d.rs1_addr = rs1_addr; d.rs2_addr = rs2_addr; d.rd_addr = rd_addr;
        d.rd_we = rd_we; d.illegal = illegal;
        return d;
    endfunction

    // Reference: table of R-type ops by funct3, legality from the ISA subset rules.
    function automatic dec_t ref_decode(input logic [31:0] w);
        alu_op_t r_ops [8] = '{i_ADD, i_SLL, i_SLT, i_SLTU, i_XOR, i_SRL, i_OR, i_AND};
        dec_t d;
        bit ok;
        ok = 0;
        d = '0;
        d.alu_op = i_ADD;
        d.imm_i = 32'($signed(w[31:20]));
        d.rs1_addr = w[19:15]; d.rs2_addr = w[24:20]; d.rd_addr = w[11:7];
        if (w[6:0] == 7'h33 && w[31:25] == 7'h00) begin
            ok = 1; d.alu_op = r_ops[w[14:12]];
        end else if (w[6:0] == 7'h33 && w[31:25] == 7'h20 && w[14:12] == 3'd0) begin
            ok = 1; d.alu_op = i_SUB;
        end else if (w[6:0] == 7'h33 && w[31:25] == 7'h20 && w[14:12] == 3'd5) begin
            ok = 1; d.alu_op = i_SRA;
        end else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin
            ok = 1; d.is_imm = 1'b1;
        end
        d.illegal = !ok;
        d.rd_we = ok && (w[11:7] != 0);
        return d;
    endfunction

    function automatic bit exp_in_ready(input bit ordy);
`ifdef DECODE_SKID_EN
        return model_q.size() < 2;
`else
        return model_q.size() == 0 || ordy;
`endif
    endfunction

    // One clock: drive, check against the model, advance the model at the edge.
    task automatic step(input bit r, input bit iv, input logic [31:0] w, input bit ordy,
                        output bit accepted);
        bit rdy, ofire;
        rst = r; in_valid = iv; instr = w; out_ready = ordy;
        #1;
        rdy = exp_in_ready(ordy);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) check("fields", 64'(observed()), 64'(model_q[0]));
        if (post_rst) check("reset_fields", 64'(observed()), 64'(0));
        accepted = iv && rdy && !r;
        ofire = (model_q.size() != 0) && ordy;
        @(posedge clk);
        if (r) model_q.delete();
        else begin
            if (ofire) void'(model_q.pop_front());
            if (accepted) model_q.push_back(ref_decode(w));
        end
        post_rst = r;
        #1;
    endtask

    task automatic expect_out(input string tag, input dec_t e);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check(tag, 64'(observed()), 64'(e));
    endtask

    function automatic dec_t mk(input alu_op_t op, input bit imm, input logic [31:0] iv,
                                input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input bit we, input bit ill);
        dec_t x;
        x.alu_op = op; x.is_imm = imm; x.imm_i = iv; x.rs1_addr = a; x.rs2_addr = b;
        x.rd_addr = d; x.rd_we = we; x.illegal = ill;
        return x;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(3))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h6F;
            default: ;
        endcase
        case ($urandom_range(2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic drain();
        bit a;
        repeat (3) step(0, 0, 32'h0, 1, a);
    endtask

    initial begin
        bit a;
        logic [31:0] seq [3];
        logic [31:0] cur;
        int unsigned idx;

        repeat (2) @(posedge clk);
        #1;
        post_rst = 1'b1;
        step(0, 0, 32'h0, 0, a);

        step(0, 1, 32'hFFF00093, 0, a);
        expect_out("addi_neg", mk(i_ADD, 1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 1, 0));
        drain();
        step(0, 1, 32'h402081B3, 0, a);
        expect_out("sub", mk(i_SUB, 0, 32'h00000402, 5'd1, 5'd2, 5'd3, 1, 0));
        drain();
        step(0, 1, 32'h0000006F, 0, a);
        expect_out("jal_illegal", mk(i_ADD, 0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 1));
        drain();
        step(0, 1, 32'h00000013, 0, a);
        expect_out("nop", mk(i_ADD, 1, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0));
        drain();

        // Three back-to-back with a stalled consumer, then release.
        seq = '{32'h002081B3, 32'h40415233, 32'h00736313};
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(0, idx < 3, idx < 3 ? seq[idx] : 32'h0, c >= 4, a);
            if (a) idx++;
        end
        check("stall_all_sent", 64'(idx), 64'(3));

        // Reset while buffered, then a lone instruction.
        step(0, 1, 32'h00A00093, 0, a);
        step(0, 1, 32'h00B00113, 0, a);
        step(0, 1, 32'h00C00193, 0, a);
        step(1, 1, 32'h00D00213, 1, a);
        step(0, 1, 32'h0020C2B3, 1, a);
        step(0, 0, 32'h0, 1, a);
        step(0, 0, 32'h0, 1, a);

        // Streaming: 8 distinct instructions at full rate.
        for (int c = 0; c < 10; c++)
            step(0, c < 8, 32'h00000033 | (c << 7) | ((c % 8) << 12), 1, a);

        cur = rand_instr();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(60) == 0, $urandom_range(3) != 0, cur,
                 $urandom_range(9) < 7, a);
            if (a || $urandom_range(7) == 0) cur = rand_instr();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
